gauss_window_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 Gaussian filter core (gauss1).
- On start, walks every interior pixel of an IMG_W x IMG_H 8-bit image held in a synchronous pixel RAM and fetches its 3x3 neighbourhood.
- For each pixel, presents the nine samples to the core, runs one core computation, and writes the 8-bit result to an output RAM.
- Output image is (IMG_W-2) x (IMG_H-2), row-major; border pixels are not produced.

---
 rtl/gauss_window_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gauss_window_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_window_ctrl.sv
// Frame sequencer for the gauss1 3x3 core: fetches each interior window, runs the core, stores the result.
// Optional cycle/pixel counters are enabled by defining GAUSS_CTRL_PERF_CNT_EN.
module gauss_window_ctrl #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int ADDR_W      = 16,
  parameter int FLT_TIMEOUT = 64
) (
  input  logic              clk_i_g,
  input  logic              rst_i_g,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [7:0]        win_o_0,
  output logic [7:0]        win_o_1,
  output logic [7:0]        win_o_2,
  output logic [7:0]        win_o_3,
  output logic [7:0]        win_o_4,
  output logic [7:0]        win_o_5,
  output logic [7:0]        win_o_6,
  output logic [7:0]        win_o_7,
  output logic [7:0]        win_o_8,
  output logic              flt_en_o,
  input  logic              flt_done_i,
  input  logic [7:0]        flt_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
`ifdef GAUSS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt_o,
  output logic [ADDR_W-1:0] pix_cnt_o
`endif
);

  // state | meaning
  // IDLE  | waiting for start_i
  // FETCH | nine window reads plus one trailing capture cycle
  // RUN   | core enabled, waiting for flt_done_i or timeout
  // WRITE | result written to output RAM
  // GAP   | core disabled for one cycle, then advance to next pixel
  // DONE  | one-cycle done_o pulse
  typedef enum logic [2:0] {IDLE, FETCH, RUN, WRITE, GAP, DONE} state_t;

  localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
  localparam int TW = (FLT_TIMEOUT > 1) ? $clog2(FLT_TIMEOUT) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 2);
  localparam logic [CW-1:0]     ROW_LAST = CW'(IMG_H - 2);
  localparam logic [TW-1:0]     TMR_LOAD = TW'(FLT_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(IMG_W - 2);

  state_t            state, state_nxt;
  logic [CW-1:0]     row, col;
  logic [3:0]        k;
  logic [TW-1:0]     tmr;
  logic [7:0]        win [9];
  logic [7:0]        result;
  logic              err;
  logic [ADDR_W-1:0] fetch_addr, out_addr;
  logic              last_pix;

  assign fetch_addr = (ADDR_W'(row) + ADDR_W'(k / 4'd3) - ADDR_W'(1)) * IMG_W_A
                    + ADDR_W'(col) + ADDR_W'(k % 4'd3) - ADDR_W'(1);
  assign out_addr   = (ADDR_W'(row) - ADDR_W'(1)) * OUT_W_A + ADDR_W'(col) - ADDR_W'(1);
  assign last_pix   = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk_i_g or negedge rst_i_g) begin
    if (!rst_i_g) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = FETCH;
      FETCH:   if (k == 4'd9) state_nxt = RUN;
      RUN:     if (flt_done_i || (tmr == '0)) state_nxt = WRITE;
      WRITE:   state_nxt = GAP;
      GAP:     state_nxt = last_pix ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i_g or negedge rst_i_g) begin
    if (!rst_i_g) begin
      row    <= '0;
      col    <= '0;
      k      <= '0;
      tmr    <= '0;
      result <= '0;
      err    <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            row <= CW'(1);
            col <= CW'(1);
            k   <= '0;
            err <= 1'b0;
          end
        end
        FETCH: begin
          // RAM data lags the read strobe by one cycle, so slot k-1 lands now
          if (k != 4'd0) win[k - 4'd1] <= rd_data_i;
          if (k == 4'd9) begin
            k   <= '0;
            tmr <= TMR_LOAD;
          end else begin
            k <= k + 4'd1;
          end
        end
        RUN: begin
          if (flt_done_i) begin
            result <= flt_data_i;
          end else if (tmr == '0) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        GAP: begin
          if (col != COL_LAST) begin
            col <= col + CW'(1);
          end else if (row != ROW_LAST) begin
            col <= CW'(1);
            row <= row + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GAUSS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk_i_g or negedge rst_i_g) begin
    if (!rst_i_g) begin
      cycle_cnt_o <= '0;
      pix_cnt_o   <= '0;
    end else if ((state == IDLE) && start_i) begin
      cycle_cnt_o <= '0;
      pix_cnt_o   <= '0;
    end else begin
      if (busy_o)  cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (wr_en_o) pix_cnt_o   <= pix_cnt_o + ADDR_W'(1);
    end
  end
`endif

  assign busy_o    = (state == FETCH) || (state == RUN) || (state == WRITE) || (state == GAP);
  assign done_o    = (state == DONE);
  assign err_o     = err;
  assign rd_en_o   = (state == FETCH) && (k != 4'd9);
  assign rd_addr_o = rd_en_o ? fetch_addr : '0;
  assign flt_en_o  = (state == RUN);
  assign wr_en_o   = (state == WRITE);
  assign wr_addr_o = wr_en_o ? out_addr : '0;
  assign wr_data_o = wr_en_o ? result : '0;

  assign win_o_0 = win[0];
  assign win_o_1 = win[1];
  assign win_o_2 = win[2];
  assign win_o_3 = win[3];
  assign win_o_4 = win[4];
  assign win_o_5 = win[5];
  assign win_o_6 = win[6];
  assign win_o_7 = win[7];
  assign win_o_8 = win[8];

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Scoreboard bench for gauss_window_ctrl: a 5x5 instance for the main frames and a 3x3 instance for the minimum case.
`timescale 1ns/1ps
module tb_gauss_window_ctrl;
  localparam int W = 5, H = 5, AW = 16, TMO = 12;
  localparam int OW = W - 2, NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // 5x5 instance
  logic          start = 1'b0;
  logic          busy, done, err, rd_en, flt_en, wr_en, flt_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = '0, flt_data = '0, wr_data;
  logic [7:0]    w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic          core_done = 1'b0, spur_done = 1'b0, core_mute = 1'b0;
  int            core_lat = 3, core_cnt = 0;
  logic [7:0]    img [W*H];
  logic [7:0]    imp [9] = '{8'd10, 8'd20, 8'd10, 8'd20, 8'd40, 8'd20, 8'd10, 8'd20, 8'd10};
  assign flt_done = core_done | spur_done;

  // 3x3 instance
  logic          start_m = 1'b0;
  logic          busy_m, done_m, err_m, rd_en_m, flt_en_m, wr_en_m, core_done_m = 1'b0;
  logic [AW-1:0] rd_addr_m, wr_addr_m;
  logic [7:0]    rd_data_m = '0, flt_data_m = '0, wr_data_m;
  logic [7:0]    m0, m1, m2, m3, m4, m5, m6, m7, m8;
  logic [7:0]    img_m [9];
  int            cnt_m = 0, wr_cnt_m = 0;

`ifdef GAUSS_CTRL_PERF_CNT_EN
  logic [31:0]   cyc, cyc_m;
  logic [AW-1:0] pix, pix_m;
`endif

  gauss_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FLT_TIMEOUT(TMO)) dut (
    .clk_i_g(clk), .rst_i_g(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .win_o_0(w0), .win_o_1(w1), .win_o_2(w2), .win_o_3(w3), .win_o_4(w4),
    .win_o_5(w5), .win_o_6(w6), .win_o_7(w7), .win_o_8(w8),
    .flt_en_o(flt_en), .flt_done_i(flt_done), .flt_data_i(flt_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
`ifdef GAUSS_CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cyc), .pix_cnt_o(pix)
`endif
  );

  gauss_window_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW), .FLT_TIMEOUT(TMO)) dut_m (
    .clk_i_g(clk), .rst_i_g(rst_n), .start_i(start_m), .busy_o(busy_m), .done_o(done_m), .err_o(err_m),
    .rd_en_o(rd_en_m), .rd_addr_o(rd_addr_m), .rd_data_i(rd_data_m),
    .win_o_0(m0), .win_o_1(m1), .win_o_2(m2), .win_o_3(m3), .win_o_4(m4),
    .win_o_5(m5), .win_o_6(m6), .win_o_7(m7), .win_o_8(m8),
    .flt_en_o(flt_en_m), .flt_done_i(core_done_m), .flt_data_i(flt_data_m),
    .wr_en_o(wr_en_m), .wr_addr_o(wr_addr_m), .wr_data_o(wr_data_m)
`ifdef GAUSS_CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cyc_m), .pix_cnt_o(pix_m)
`endif
  );

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // 1-2-1 binomial kernel, packed window with sample 0 in the low byte
  function automatic logic [7:0] gauss9(input logic [71:0] v);
    int s = 0;
    for (int i = 0; i < 9; i++)
      s += ((i == 4) ? 4 : ((i % 2) == 1) ? 2 : 1) * int'(v[i*8 +: 8]);
    return 8'(s >> 4);
  endfunction

  function automatic logic [7:0] ref_pix(input int r, input int c);
    logic [71:0] v;
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        v[n*8 +: 8] = img[(r + dr) * W + (c + dc)];
        n++;
      end
    return gauss9(v);
  endfunction

  // pixel RAMs, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en && (rd_addr < AW'(W*H))) rd_data <= img[rd_addr];
    if (rd_en_m && (rd_addr_m < AW'(9))) rd_data_m <= img_m[rd_addr_m];
  end

  // core models: done strobe core_lat (5x5) or 2 (3x3) cycles after enable
  always @(posedge clk) begin
    if (!flt_en) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (!core_mute && (core_cnt == core_lat - 1)) begin
        core_done <= 1'b1;
        flt_data  <= gauss9({w8, w7, w6, w5, w4, w3, w2, w1, w0});
      end else begin
        core_done <= 1'b0;
      end
    end
    if (!flt_en_m) begin
      cnt_m       <= 0;
      core_done_m <= 1'b0;
    end else begin
      cnt_m       <= cnt_m + 1;
      core_done_m <= (cnt_m == 1);
      flt_data_m  <= gauss9({m8, m7, m6, m5, m4, m3, m2, m1, m0});
    end
  end

  logic [23:0] sb [$];
  logic [23:0] ent;
  int wr_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cnt++;
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(ent[23:8]));
        chk("wr_data", 32'(wr_data), 32'(ent[7:0]));
      end
    end
    if (wr_en_m) begin
      wr_cnt_m++;
      chk("m_wr_addr", 32'(wr_addr_m), 32'd0);
      chk("m_wr_data", 32'(wr_data_m), 32'd255);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic push_frame();
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        sb.push_back({16'((r - 1) * OW + (c - 1)), ref_pix(r, c)});
  endtask

  task automatic wait_flt_en(input string tag);
    int n = 0;
    while (!flt_en && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(flt_en), 32'd1);
  endtask

  task automatic finish_frame(input int wr0, input string tag);
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(NOUT));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int t0, n, d0, w_at;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd", 32'({rd_en, rd_addr}), 32'd0);
    chk("rst_flt_en", 32'(flt_en), 32'd0);
    chk("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
    chk("rst_win", 32'(w0 | w1 | w2 | w3 | w4 | w5 | w6 | w7 | w8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // uniform 100, with the first window's read sequence checked cycle by cycle
    for (int i = 0; i < W*H; i++) img[i] = 8'd100;
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("fetch_rd_en", 32'(rd_en), 32'(i < 9));
      if (i < 9) chk("fetch_addr", 32'(rd_addr), 32'((i / 3) * W + (i % 3)));
      chk("fetch_flt_en", 32'(flt_en), 32'd0);
      @(negedge clk);
    end
    chk("run_flt_en", 32'(flt_en), 32'd1);
    chk("run_win_centre", 32'(w4), 32'd100);
    finish_frame(t0, "uni");

    // single 160 impulse at (2,2)
    for (int i = 0; i < W*H; i++) img[i] = 8'd0;
    img[2*W + 2] = 8'd160;
    for (int a = 0; a < 9; a++) sb.push_back({16'(a), imp[a]});
    t0 = wr_cnt;
    pulse_start();
    finish_frame(t0, "imp");

    // saturated image
    for (int i = 0; i < W*H; i++) img[i] = 8'd255;
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    finish_frame(t0, "sat");

    // random image, start re-pulsed in FETCH and RUN, stray done in FETCH
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 255));
    core_lat = 1 + $urandom_range(0, 4);
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; spur_done = 1'b1; end
    @(negedge clk) spur_done = 1'b0;
    wait_flt_en("rob_reach_run");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    finish_frame(t0, "rob");
    core_lat = 3;

    // core never answers: every pixel times out and writes 0
    core_mute = 1'b1;
    for (int a = 0; a < NOUT; a++) sb.push_back({16'(a), 8'h00});
    t0 = wr_cnt;
    pulse_start();
    wait_flt_en("tmo_reach_run");
    chk("tmo_err_before", 32'(err), 32'd0);
    n = 0;
    while (flt_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_run_len", 32'(n), 32'(TMO));
    chk("tmo_err_set", 32'(err), 32'd1);
    finish_frame(t0, "tmo");
    chk("tmo_err_sticky", 32'(err), 32'd1);
    core_mute = 1'b0;

    // next start clears err and runs normally
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 255));
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    finish_frame(t0, "post_tmo");

    // async reset during RUN of the second pixel
    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(1, 255));
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    n = 0;
    while (wr_cnt == t0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_first_wr", 32'(wr_cnt - t0), 32'd1);
    wait_flt_en("rstmid_reach_run");
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_flt_en", 32'(flt_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
    chk("rstmid_rd", 32'({rd_en, rd_addr}), 32'd0);
    chk("rstmid_win", 32'(w0 | w1 | w2 | w3 | w4 | w5 | w6 | w7 | w8), 32'd0);
    sb.delete();
    d0   = done_cnt;
    w_at = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_no_wr", 32'(wr_cnt), 32'(w_at));
    chk("rstmid_no_done", 32'(done_cnt), 32'(d0));
    push_frame();
    t0 = wr_cnt;
    pulse_start();
    finish_frame(t0, "after_rst");

    // minimum 3x3 frame on the second instance
    for (int i = 0; i < 9; i++) img_m[i] = 8'd255;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("m_rd_en", 32'(rd_en_m), 32'(i < 9));
      if (i < 9) chk("m_rd_addr", 32'(rd_addr_m), 32'(i));
      @(negedge clk);
    end
    n = 0;
    while (!done_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("m_done", 32'(done_m), 32'd1);
    chk("m_busy_low", 32'(busy_m), 32'd0);
    chk("m_wr_count", 32'(wr_cnt_m), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
